seq_mult_unit: RTL and testbench
================================

Name: seq_mult_unit

Overview:
- Iterative radix-2 shift-add unsigned multiplier for the execute stage.
- Sits directly upstream of the 4-bit CLA slice: each cycle it feeds the adder the partial-product accumulator and the multiplicand, then consumes the sum and carry-out.
- The adder is WIDTH/4 chained CLA_4bit instances (ripple between slices; carry-in to slice 0 tied 0).
- Valid/ready handshake on both sides so the pipeline control can stall around it.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start_valid  input  1  operands a/b valid
- start_ready  output  1  unit can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- res_valid  output  1  product valid
- res_ready  input  1  consumer accepts product
- product  output  2*WIDTH  unsigned a*b
- busy  output  1  iteration in progress

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, start_ready=1, res_valid=0, busy=0, product=0, counter=0, internal registers=0. Reset takes priority over every other event, including mid-iteration and while res_valid=1. Any in-flight operation is discarded.
- States:
  - IDLE: start_ready=1. On start_valid&&start_ready: mcand<=a, acc<=0, mplier<=b, cnt<=0, go to BUSY.
  - BUSY: busy=1, start_ready=0. Each cycle {c,s} = mplier[0] ? acc+mcand (CLA chain, WIDTH+1 bits) : {0,acc}. Then {acc,mplier} <= {c,s,mplier}>>1, and cnt<=cnt+1. When cnt==WIDTH-1 (last iteration), go to DONE.
  - DONE: res_valid=1, product={acc,mplier}, held stable while res_ready=0. On res_ready go to IDLE, and res_valid drops next cycle.
- Latency without the optional feature: accept edge, then exactly WIDTH BUSY cycles, then res_valid high. The first result is available WIDTH+1 cycles after the accept edge.
- start_ready is low in BUSY and DONE. start_valid is ignored there and a/b are not sampled.
- product holds its last value in IDLE (it is 0 after reset). It changes only on the transition into DONE.
- Arithmetic: the carry out of the top CLA slice shifts into acc MSB. No overflow is possible: the product fits in 2*WIDTH bits.
- Boundary cases:
  - a=0 or b=0: product=0, same latency.
  - a=b=2^WIDTH-1: product=2^(2W)-2^(W+1)+1.
  - Simultaneous start_valid and res_ready in DONE: the unit returns to IDLE only. The new start is accepted no earlier than the following cycle.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: after each iteration, if the shifted remaining multiplier bits (not yet consumed) are all zero, finish immediately. The final {acc,mplier} is right-aligned by the WIDTH-1-cnt remaining positions in that same cycle, and the state goes to DONE.
  - BUSY cycles = max(1, msb_index(b)+1). Example: b=0 gives 1 cycle; b=5 gives 3 cycles.
  - The product value is identical to the non-early result.
- Undefined: fixed WIDTH BUSY cycles, with no alignment shifter synthesized.

Test Plan:
- WIDTH=8. Reset, then a=3, b=5, start_valid=1, res_ready=1: start_ready drops the cycle after accept, res_valid rises 9 cycles after accept edge with product=15, and the unit returns to IDLE the next cycle.
- WIDTH=8. a=255, b=255: product=65025 (0xFE01). Also a=0, b=200 gives product=0 and a=200, b=0 gives product=0, both with the 8-cycle BUSY count.
- Backpressure: a=12, b=11, res_ready=0 for 5 cycles after res_valid. product=132 is held stable, start_valid pulses are ignored (start_ready=0), and one res_ready pulse gives res_valid=0 next cycle.
- Reset mid-op: a=100, b=100, reset_n=0 on the 4th BUSY cycle. Next cycle state is IDLE, res_valid=0, product=0, start_ready=1. A new op a=7, b=6 then yields 42.
- Back-to-back: 10 random pairs with start_valid held high and res_ready=1. Every product matches the reference a*b, each op is accepted only from IDLE, and no op is lost or duplicated.
- With SEQ_MULT_EARLY_TERM_EN: b=0 gives 1 BUSY cycle, product 0; a=9, b=5 gives 3 BUSY cycles, product 45; b=128 gives 8 cycles. Products are identical to runs with the macro off.

Source files
------------

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative radix-2 shift-add unsigned multiplier.
// Ports: clk, reset_n (sync, active low); start_valid/start_ready/a/b in,
//        res_valid/res_ready/product out; busy while iterating.
// Optional macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the unconsumed
// multiplier bits are all zero, right-aligning the result in that cycle.

module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ c;
endmodule

module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int NSL   = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   sum;
    logic [NSL:0]       carry;
    logic [WIDTH:0]     add;
    logic [2*WIDTH-1:0] nxt;
    logic [2*WIDTH-1:0] fin;
    logic               last;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NSL; i++) begin : g_cla
        cla_4bit u_cla (
            .a  (acc[4*i +: 4]),
            .b  (mcand[4*i +: 4]),
            .ci (carry[i]),
            .s  (sum[4*i +: 4]),
            .co (carry[i+1])
        );
    end

    // Add only when the current multiplier LSB is set; carry enters acc MSB.
    assign add = mplier[0] ? {carry[NSL], sum} : {1'b0, acc};
    assign nxt = {add, mplier[WIDTH-1:1]};

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] mask;

    // Low rem bits of the shifted multiplier are still-unconsumed b bits.
    assign rem  = CNT_W'(WIDTH - 1) - cnt;
    assign mask = {WIDTH{1'b1}} >> (cnt + CNT_W'(1));
    assign last = (cnt == CNT_W'(WIDTH - 1))
               || ((nxt[WIDTH-1:0] & mask) == '0);
    assign fin  = nxt >> rem;
`else
    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign fin  = nxt;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            product     <= '0;
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        mcand       <= a;
                        acc         <= '0;
                        mplier      <= b;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        acc       <= fin[2*WIDTH-1:WIDTH];
                        mplier    <= fin[WIDTH-1:0];
                        product   <= fin;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        acc    <= nxt[2*WIDTH-1:WIDTH];
                        mplier <= nxt[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit: randomized self-checking bench for seq_mult_unit.
// Drives WIDTH=8 operations and checks against plain a*b arithmetic.

module tb_seq_mult_unit;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           busy;

    int n_pass = 0;
    int n_chk  = 0;

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .product     (product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_busy(input logic [W-1:0] mb);
        int n;
`ifdef SEQ_MULT_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < W; i++)
            if (mb[i]) n = i + 1;
`else
        n = W;
`endif
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait for res_valid (bounded); no checking here.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output int nbusy, output int lat,
                          output logic sr_after, output logic tout);
        a = ia;
        b = ib;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        sr_after = start_ready;
        nbusy = 0;
        lat = 1;
        tout = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (res_valid) begin
                tout = 1'b0;
                break;
            end
            if (busy) nbusy++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        n_chk++;
        if (start_ready !== 1'b1) $display("FAIL rst_start_ready got %b want 1", start_ready);
        else n_pass++;
        n_chk++;
        if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b want 0", res_valid);
        else n_pass++;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
        else n_pass++;
        n_chk++;
        if (product !== '0) $display("FAIL rst_product got %0d want 0", product);
        else n_pass++;
    endtask

    task automatic test_basic();
        int nb, lat;
        logic sr, to;
        res_ready = 1'b1;
        run_op(8'd3, 8'd5, nb, lat, sr, to);
        n_chk++;
        if (to) $display("FAIL basic_timeout got timeout want res_valid");
        else n_pass++;
        n_chk++;
        if (sr !== 1'b0) $display("FAIL basic_start_ready got %b want 0", sr);
        else n_pass++;
        n_chk++;
        if (product !== 16'd15) $display("FAIL basic_product got %0d want 15", product);
        else n_pass++;
        n_chk++;
        if (lat != exp_busy(8'd5) + 1) $display("FAIL basic_latency got %0d want %0d", lat, exp_busy(8'd5) + 1);
        else n_pass++;
        n_chk++;
        if (nb != exp_busy(8'd5)) $display("FAIL basic_busy got %0d want %0d", nb, exp_busy(8'd5));
        else n_pass++;
        step();
        n_chk++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL basic_idle got rv=%b sr=%b want rv=0 sr=1", res_valid, start_ready);
        else n_pass++;
    endtask

    task automatic test_boundary();
        logic [W-1:0] ta [3] = '{8'd255, 8'd0, 8'd200};
        logic [W-1:0] tb [3] = '{8'd255, 8'd200, 8'd0};
        int nb, lat;
        logic sr, to;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], nb, lat, sr, to);
            n_chk++;
            if (to || product !== 16'(ta[i] * tb[i]))
                $display("FAIL bound_product[%0d] got %0d to=%b want %0d", i, product, to, ta[i] * tb[i]);
            else n_pass++;
            n_chk++;
            if (nb != exp_busy(tb[i]))
                $display("FAIL bound_busy[%0d] got %0d want %0d", i, nb, exp_busy(tb[i]));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_backpressure();
        int nb, lat;
        logic sr, to;
        int bad;
        res_ready = 1'b0;
        run_op(8'd12, 8'd11, nb, lat, sr, to);
        n_chk++;
        if (to || product !== 16'd132) $display("FAIL bp_product got %0d to=%b want 132", product, to);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            start_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            step();
            if (product !== 16'd132 || res_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b0)
                bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        else n_pass++;
        // start_valid and res_ready together in DONE: only return to IDLE.
        a = 8'd3;
        b = 8'd4;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_chk++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1)
            $display("FAIL bp_release got rv=%b busy=%b sr=%b want 0 0 1", res_valid, busy, start_ready);
        else n_pass++;
        res_ready = 1'b1;
        run_op(8'd3, 8'd4, nb, lat, sr, to);
        n_chk++;
        if (to || product !== 16'd12 || sr !== 1'b0)
            $display("FAIL bp_next got %0d to=%b sr=%b want 12", product, to, sr);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        int nb, lat;
        logic sr, to;
        res_ready = 1'b1;
        a = 8'd100;
        b = 8'd100;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_chk++;
        if (res_valid !== 1'b0 || product !== '0 || start_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL midrst_state got rv=%b p=%0d sr=%b busy=%b want 0 0 1 0",
                     res_valid, product, start_ready, busy);
        else n_pass++;
        run_op(8'd7, 8'd6, nb, lat, sr, to);
        n_chk++;
        if (to || product !== 16'd42) $display("FAIL midrst_product got %0d to=%b want 42", product, to);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   pa [10];
        logic [W-1:0]   pb [10];
        logic [2*W-1:0] expq [$];
        int idx, got, viol;
        logic acc;
        for (int i = 0; i < 10; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        pb[0] = 8'd255;
        res_ready = 1'b1;
        idx = 0;
        got = 0;
        viol = 0;
        a = pa[0];
        b = pb[0];
        start_valid = 1'b1;
        for (int k = 0; k < 400 && got < 10; k++) begin
            if (res_valid) begin
                n_chk++;
                if (expq.size() == 0) $display("FAIL b2b_extra got %0d want none", product);
                else if (product !== expq[0])
                    $display("FAIL b2b_product[%0d] got %0d want %0d", got, product, expq[0]);
                else n_pass++;
                if (expq.size() != 0) void'(expq.pop_front());
                got++;
            end
            if (start_ready && (busy || res_valid)) viol++;
            acc = start_valid && start_ready;
            if (acc) expq.push_back(16'(a * b));
            step();
            if (acc) begin
                idx++;
                if (idx < 10) begin
                    a = pa[idx];
                    b = pb[idx];
                end else start_valid = 1'b0;
            end
        end
        start_valid = 1'b0;
        n_chk++;
        if (got != 10 || idx != 10 || expq.size() != 0)
            $display("FAIL b2b_count got res=%0d acc=%0d left=%0d want 10 10 0", got, idx, expq.size());
        else n_pass++;
        n_chk++;
        if (viol != 0) $display("FAIL b2b_ready got %0d violations want 0", viol);
        else n_pass++;
        step();
    endtask

    task automatic test_early();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3] = '{8'd0, 8'd5, 8'd128};
        int nb, lat;
        logic sr, to;
        ta[0] = W'($urandom);
        ta[1] = 8'd9;
        ta[2] = W'($urandom);
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], nb, lat, sr, to);
            n_chk++;
            if (to || product !== 16'(ta[i] * tb[i]))
                $display("FAIL early_product[%0d] got %0d want %0d", i, product, ta[i] * tb[i]);
            else n_pass++;
            n_chk++;
            if (nb != exp_busy(tb[i]) || lat != exp_busy(tb[i]) + 1)
                $display("FAIL early_busy[%0d] got %0d/%0d want %0d", i, nb, lat, exp_busy(tb[i]));
            else n_pass++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_early();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
